// File: rtl/thread_ready_queue.sv
// Ordered FIFO of runnable thread IDs feeding the Scheduler, with head/second-entry lookahead.
// Optional feature: define READY_QUEUE_DUP_CHECK_EN to drop pushes of IDs already queued.
package EV_types;
    typedef logic [7:0] thread_id_t;
endpackage

module thread_ready_queue
    import EV_types::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push_valid,
    input  thread_id_t push_id,
    output logic       push_ready,
    input  logic       requesting_thread,
    input  thread_id_t requested_thread_id,
    output thread_id_t waiting_thread_count,
    output thread_id_t waiting_next_id,
    output thread_id_t waiting_next_id2,
    output logic       overflow,
    output logic       pop_error
);

    localparam int TID_W = $bits(thread_id_t);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);
    localparam thread_id_t ID_ZERO = {TID_W{1'b0}};

    thread_id_t       mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             overflow_r;
    logic             pop_error_r;

    logic             full_s;
    logic             pop_valid_s;
    logic             dup_drop_s;
    logic             push_accept_s;
    logic [PTR_W:0]   count_next_s;

    assign full_s      = (count_r == COUNT_FULL);
    assign pop_valid_s = requesting_thread && (count_r != {(PTR_W+1){1'b0}})
                         && (requested_thread_id == mem_r[rd_ptr_r]);

`ifdef READY_QUEUE_DUP_CHECK_EN
    logic [DEPTH-1:0] match_s;

    // An entry matches if it is occupied and is not the head slot being popped this cycle.
    for (genvar g = 0; g < DEPTH; g++) begin : g_dup
        logic [PTR_W-1:0] offset_s;
        assign offset_s   = PTR_W'(g) - rd_ptr_r;
        assign match_s[g] = ({1'b0, offset_s} < count_r)
                            && (mem_r[g] == push_id)
                            && !(pop_valid_s && (PTR_W'(g) == rd_ptr_r));
    end
    assign dup_drop_s = |match_s;
`else
    assign dup_drop_s = 1'b0;
`endif

    // A full queue still accepts a push when the same cycle frees the head slot.
    assign push_accept_s = push_valid && (!full_s || pop_valid_s) && !dup_drop_s;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_accept_s, pop_valid_s})
            2'b10:   count_next_s = count_r + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{PTR_W{1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // Queue storage, pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ID_ZERO;
            end
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {(PTR_W+1){1'b0}};
            overflow_r  <= 1'b0;
            pop_error_r <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ID_ZERO;
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            // Clear before write: when full, push and pop share the same slot and the push must win.
            if (pop_valid_s) begin
                mem_r[rd_ptr_r] <= ID_ZERO;
                rd_ptr_r        <= rd_ptr_r + PTR_ONE;
            end
            if (push_accept_s) begin
                mem_r[wr_ptr_r] <= push_id;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            if (requesting_thread && !pop_valid_s) begin
                pop_error_r <= 1'b1;
            end
            if (push_valid && full_s && !pop_valid_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign push_ready           = !full_s;
    assign waiting_thread_count = thread_id_t'(count_r);
    assign waiting_next_id      = (count_r != {(PTR_W+1){1'b0}}) ? mem_r[rd_ptr_r] : ID_ZERO;
    assign waiting_next_id2     = (count_r > {{PTR_W{1'b0}}, 1'b1}) ? mem_r[rd_ptr_r + PTR_ONE] : ID_ZERO;
    assign overflow             = overflow_r;
    assign pop_error            = pop_error_r;

endmodule

// File: tb/tb_thread_ready_queue.sv
// Self-checking bench for thread_ready_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_thread_ready_queue;
    import EV_types::*;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       push_valid;
    thread_id_t push_id;
    logic       push_ready;
    logic       requesting_thread;
    thread_id_t requested_thread_id;
    thread_id_t waiting_thread_count;
    thread_id_t waiting_next_id;
    thread_id_t waiting_next_id2;
    logic       overflow;
    logic       pop_error;

    int tests_run;
    int tests_failed;

    int q[$];
    bit m_ovf;
    bit m_perr;

    thread_ready_queue #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .push_valid          (push_valid),
        .push_id             (push_id),
        .push_ready          (push_ready),
        .requesting_thread   (requesting_thread),
        .requested_thread_id (requested_thread_id),
        .waiting_thread_count(waiting_thread_count),
        .waiting_next_id     (waiting_next_id),
        .waiting_next_id2    (waiting_next_id2),
        .overflow            (overflow),
        .pop_error           (pop_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and advance the reference model by the queue rules.
    task automatic cycle(input bit pv, input int pid, input bit rq, input int rid, input bit fl);
        bit pop_ok;
        bit dup;
        bit take;
        push_valid          = pv;
        push_id             = 8'(pid);
        requesting_thread   = rq;
        requested_thread_id = 8'(rid);
        flush               = fl;
        pop_ok = 1'b0;
        dup    = 1'b0;
        take   = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            pop_ok = rq && (q.size() > 0) && (rid == q[0]);
            if (rq && !pop_ok) m_perr = 1'b1;
            if (pv) begin
                if (q.size() == DEPTH && !pop_ok) begin
                    m_ovf = 1'b1;
                end else begin
`ifdef READY_QUEUE_DUP_CHECK_EN
                    for (int k = (pop_ok ? 1 : 0); k < q.size(); k++) begin
                        if (q[k] == pid) dup = 1'b1;
                    end
`endif
                    take = !dup;
                end
            end
            if (pop_ok) void'(q.pop_front());
            if (take) q.push_back(pid);
        end
        @(posedge clk);
        #1;
        push_valid        = 1'b0;
        requesting_thread = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        q.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 33, 1'b0, 0, 1'b0);
        cycle(1'b1, 44, 1'b0, 0, 1'b0);
        cycle(1'b1, 55, 1'b1, 99, 1'b0);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (waiting_thread_count !== 8'd0) begin
            tests_failed++; $display("FAIL reset_count got %0d want 0", waiting_thread_count);
        end
        tests_run++;
        if (waiting_next_id !== 8'd0 || waiting_next_id2 !== 8'd0) begin
            tests_failed++; $display("FAIL reset_ids got %0d/%0d want 0/0", waiting_next_id, waiting_next_id2);
        end
        tests_run++;
        if (push_ready !== 1'b1 || overflow !== 1'b0 || pop_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got ready=%b ovf=%b perr=%b want 1/0/0", push_ready, overflow, pop_error);
        end
        q.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_push_pop();
        do_reset();
        cycle(1'b1, 15, 1'b0, 0, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd1 || waiting_next_id !== 8'd15 || waiting_next_id2 !== 8'd0) begin
            tests_failed++;
            $display("FAIL push15 got cnt=%0d id=%0d id2=%0d want 1/15/0", waiting_thread_count, waiting_next_id, waiting_next_id2);
        end
        cycle(1'b0, 0, 1'b1, 15, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd0 || waiting_next_id !== 8'd0) begin
            tests_failed++; $display("FAIL pop15 got cnt=%0d id=%0d want 0/0", waiting_thread_count, waiting_next_id);
        end
        cycle(1'b1, 56, 1'b0, 0, 1'b0);
        cycle(1'b1, 65, 1'b0, 0, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd2 || waiting_next_id !== 8'd56 || waiting_next_id2 !== 8'd65) begin
            tests_failed++;
            $display("FAIL push56_65 got cnt=%0d id=%0d id2=%0d want 2/56/65", waiting_thread_count, waiting_next_id, waiting_next_id2);
        end
        cycle(1'b0, 0, 1'b1, 56, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd1 || waiting_next_id !== 8'd65 || waiting_next_id2 !== 8'd0) begin
            tests_failed++;
            $display("FAIL pop56 got cnt=%0d id=%0d id2=%0d want 1/65/0", waiting_thread_count, waiting_next_id, waiting_next_id2);
        end
        cycle(1'b0, 0, 1'b1, 65, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd0 || pop_error !== 1'b0) begin
            tests_failed++; $display("FAIL pop65 got cnt=%0d perr=%b want 0/0", waiting_thread_count, pop_error);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, i, 1'b0, 0, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd16 || push_ready !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill got cnt=%0d ready=%b ovf=%b want 16/0/0", waiting_thread_count, push_ready, overflow);
        end
        cycle(1'b1, 17, 1'b0, 0, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd16 || overflow !== 1'b1 || waiting_next_id !== 8'd1) begin
            tests_failed++;
            $display("FAIL overflow got cnt=%0d ovf=%b id=%0d want 16/1/1", waiting_thread_count, overflow, waiting_next_id);
        end
        cycle(1'b1, 17, 1'b1, 1, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd16 || waiting_next_id !== 8'd2 || waiting_next_id2 !== 8'd3 || pop_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_push_pop got cnt=%0d id=%0d id2=%0d perr=%b want 16/2/3/0",
                     waiting_thread_count, waiting_next_id, waiting_next_id2, pop_error);
        end
        for (int k = 2; k <= 17; k++) begin
            tests_run++;
            if (waiting_next_id !== 8'(k)) begin
                tests_failed++; $display("FAIL drain_order got %0d want %0d", waiting_next_id, k);
            end
            cycle(1'b0, 0, 1'b1, k, 1'b0);
        end
        tests_run++;
        if (waiting_thread_count !== 8'd0 || pop_error !== 1'b0) begin
            tests_failed++; $display("FAIL drained got cnt=%0d perr=%b want 0/0", waiting_thread_count, pop_error);
        end
        for (int i = 0; i < 20; i++) begin
            if (i >= 3) begin
                tests_run++;
                if (waiting_next_id !== 8'(100 + i - 3)) begin
                    tests_failed++; $display("FAIL wrap_order got %0d want %0d", waiting_next_id, 100 + i - 3);
                end
            end
            cycle(1'b1, 100 + i, (i >= 3), 100 + i - 3, 1'b0);
        end
        tests_run++;
        if (waiting_thread_count !== 8'd3 || waiting_next_id !== 8'd117 || waiting_next_id2 !== 8'd118) begin
            tests_failed++;
            $display("FAIL wrap_end got cnt=%0d id=%0d id2=%0d want 3/117/118", waiting_thread_count, waiting_next_id, waiting_next_id2);
        end
    endtask

    task automatic test_pop_error_flush();
        do_reset();
        cycle(1'b1, 3, 1'b0, 0, 1'b0);
        cycle(1'b1, 4, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 9, 1'b0);
        tests_run++;
        if (pop_error !== 1'b1 || waiting_thread_count !== 8'd2 || waiting_next_id !== 8'd3) begin
            tests_failed++;
            $display("FAIL pop_mismatch got perr=%b cnt=%0d id=%0d want 1/2/3", pop_error, waiting_thread_count, waiting_next_id);
        end
        do_reset();
        cycle(1'b0, 0, 1'b1, 0, 1'b0);
        tests_run++;
        if (pop_error !== 1'b1 || waiting_thread_count !== 8'd0) begin
            tests_failed++; $display("FAIL pop_empty got perr=%b cnt=%0d want 1/0", pop_error, waiting_thread_count);
        end
        cycle(1'b1, 5, 1'b0, 0, 1'b0);
        cycle(1'b1, 6, 1'b0, 0, 1'b0);
        cycle(1'b1, 7, 1'b1, 5, 1'b1);
        tests_run++;
        if (waiting_thread_count !== 8'd0 || waiting_next_id !== 8'd0 || pop_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush got cnt=%0d id=%0d perr=%b want 0/0/1", waiting_thread_count, waiting_next_id, pop_error);
        end
        cycle(1'b1, 42, 1'b0, 0, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd1 || waiting_next_id !== 8'd42 || waiting_next_id2 !== 8'd0) begin
            tests_failed++;
            $display("FAIL post_flush got cnt=%0d id=%0d id2=%0d want 1/42/0", waiting_thread_count, waiting_next_id, waiting_next_id2);
        end
    endtask

    task automatic test_dup();
        do_reset();
        cycle(1'b1, 7, 1'b0, 0, 1'b0);
        cycle(1'b1, 7, 1'b0, 0, 1'b0);
        tests_run++;
`ifdef READY_QUEUE_DUP_CHECK_EN
        if (waiting_thread_count !== 8'd1 || waiting_next_id !== 8'd7 || waiting_next_id2 !== 8'd0) begin
            tests_failed++;
            $display("FAIL dup_drop got cnt=%0d id=%0d id2=%0d want 1/7/0", waiting_thread_count, waiting_next_id, waiting_next_id2);
        end
        cycle(1'b1, 7, 1'b1, 7, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd1 || waiting_next_id !== 8'd7 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL dup_with_pop got cnt=%0d id=%0d ovf=%b want 1/7/0", waiting_thread_count, waiting_next_id, overflow);
        end
`else
        if (waiting_thread_count !== 8'd2 || waiting_next_id !== 8'd7 || waiting_next_id2 !== 8'd7) begin
            tests_failed++;
            $display("FAIL dup_keep got cnt=%0d id=%0d id2=%0d want 2/7/7", waiting_thread_count, waiting_next_id, waiting_next_id2);
        end
        cycle(1'b1, 7, 1'b1, 7, 1'b0);
        tests_run++;
        if (waiting_thread_count !== 8'd2 || waiting_next_id !== 8'd7 || waiting_next_id2 !== 8'd7) begin
            tests_failed++;
            $display("FAIL dup_with_pop got cnt=%0d id=%0d id2=%0d want 2/7/7", waiting_thread_count, waiting_next_id, waiting_next_id2);
        end
`endif
    endtask

    task automatic test_random();
        int  e_cnt;
        int  e_id;
        int  e_id2;
        bit  e_rdy;
        bit  pv;
        bit  rq;
        bit  fl;
        int  pid;
        int  rid;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 199) do_reset();
            pv  = ($urandom_range(0, 99) < 60);
            pid = $urandom_range(1, 20);
            rq  = ($urandom_range(0, 99) < 45);
            rid = (q.size() > 0 && $urandom_range(0, 9) < 8) ? q[0] : $urandom_range(0, 25);
            fl  = ($urandom_range(0, 149) == 0);
            cycle(pv, pid, rq, rid, fl);
            e_cnt = q.size();
            e_id  = (q.size() > 0) ? q[0] : 0;
            e_id2 = (q.size() > 1) ? q[1] : 0;
            e_rdy = (q.size() < DEPTH);
            tests_run++;
            if (waiting_thread_count !== 8'(e_cnt) || waiting_next_id !== 8'(e_id) || waiting_next_id2 !== 8'(e_id2)
                || push_ready !== e_rdy || overflow !== m_ovf || pop_error !== m_perr) begin
                tests_failed++;
                $display("FAIL random[%0d] got cnt=%0d id=%0d id2=%0d rdy=%b ovf=%b perr=%b want %0d/%0d/%0d/%b/%b/%b",
                         n, waiting_thread_count, waiting_next_id, waiting_next_id2, push_ready, overflow, pop_error,
                         e_cnt, e_id, e_id2, e_rdy, m_ovf, m_perr);
            end
        end
    endtask

    initial begin
        tests_run           = 0;
        tests_failed        = 0;
        m_ovf               = 1'b0;
        m_perr              = 1'b0;
        rst                 = 1'b0;
        flush               = 1'b0;
        push_valid          = 1'b0;
        push_id             = 8'd0;
        requesting_thread   = 1'b0;
        requested_thread_id = 8'd0;
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_push_pop();
        test_full_wrap();
        test_pop_error_flush();
        test_dup();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
